half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 12 +
 rtl/half_adder_if.sv | 25 ++
 rtl/half_adder_cell.sv | 13 +
 rtl/half_adder.sv | 56 +++++
 tb/tb_half_adder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half-adder slice: default lane count
// and the single-lane arithmetic used by every cell.
package half_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Returns {carry, sum} for one 1-bit lane.
  function automatic logic [1:0] ha_eval(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle of the half adder; master drives operands, slave returns results.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry
  );

endinterface

// File: rtl/half_adder_cell.sv
// One combinational 1-bit half-adder lane.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign {carry, sum} = ha_eval(a, b);

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a one-cycle registered result and
// valid qualifier; results hold while no valid operands arrive.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic        clk,
  input logic        rst,
  half_adder_if.slave bus
);

  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_carry;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    half_adder_cell u_cell (
      .a     (bus.a[gi]),
      .b     (bus.b[gi]),
      .sum   (lane_sum[gi]),
      .carry (lane_carry[gi])
    );
  end

  // Operands only pass the mux when valid, so X on idle a/b never lands in the flops.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d   = lane_sum;
      carry_d = lane_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench: 1-lane and 4-lane half adders plus a two-stage full adder
// built from two half adders with aligned delays.
module tb_half_adder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  half_adder_if #(.WIDTH(1)) if1 ();
  half_adder_if #(.WIDTH(4)) if4 ();
  half_adder_if #(.WIDTH(1)) fa1 ();
  half_adder_if #(.WIDTH(1)) fa2 ();

  half_adder #(.WIDTH(1)) u_w1  (.clk(clk), .rst(rst), .bus(if1));
  half_adder #(.WIDTH(4)) u_w4  (.clk(clk), .rst(rst), .bus(if4));
  half_adder #(.WIDTH(1)) u_fa1 (.clk(clk), .rst(rst), .bus(fa1));
  half_adder #(.WIDTH(1)) u_fa2 (.clk(clk), .rst(rst), .bus(fa2));

  // Full-adder glue: stage 2 adds S1 to C delayed by one cycle; C1 is delayed to meet C2.
  logic fa_c;
  logic c_d;
  logic c1_d;
  logic fa_sum;
  logic fa_carry;

  always @(posedge clk) begin
    c_d  <= fa_c;
    c1_d <= fa1.carry;
  end

  assign fa2.in_valid = fa1.out_valid;
  assign fa2.a        = fa1.sum;
  assign fa2.b        = c_d;
  assign fa_sum       = fa2.sum;
  assign fa_carry     = c1_d | fa2.carry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic a, input logic b);
    if1.in_valid = v;
    if1.a        = a;
    if1.b        = b;
  endtask

  task automatic check1(input string tag, input logic ov, input logic c, input logic s);
    check({tag, "_ov"},    {7'd0, if1.out_valid}, {7'd0, ov});
    check({tag, "_carry"}, {7'd0, if1.carry},     {7'd0, c});
    check({tag, "_sum"},   {7'd0, if1.sum},       {7'd0, s});
    $display("w1 %s: a=%b b=%b ov=%b carry=%b sum=%b", tag, if1.a, if1.b,
             if1.out_valid, if1.carry, if1.sum);
  endtask

  task automatic check4(input string tag, input logic [3:0] c, input logic [3:0] s);
    check({tag, "_ov"},    {7'd0, if4.out_valid}, 8'd1);
    check({tag, "_carry"}, {4'd0, if4.carry},     {4'd0, c});
    check({tag, "_sum"},   {4'd0, if4.sum},       {4'd0, s});
    $display("w4 %s: carry=%b sum=%b", tag, if4.carry, if4.sum);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive1(1'b1, 1'b1, 1'b1);
    if4.in_valid = 1'b1;
    if4.a        = 4'hF;
    if4.b        = 4'hF;
    fa1.in_valid = 1'b1;
    fa1.a        = 1'b1;
    fa1.b        = 1'b1;
    fa_c         = 1'b1;
    @(negedge clk);

    // Reset held two cycles with valid operands present
    step();
    check1("rst0", 1'b0, 1'b0, 1'b0);
    check("rst0_w4_ov", {7'd0, if4.out_valid}, 8'd0);
    check("rst0_w4_sum", {4'd0, if4.sum}, 8'd0);
    step();
    check1("rst1", 1'b0, 1'b0, 1'b0);
    check("rst1_w4_carry", {4'd0, if4.carry}, 8'd0);

    // Exhaustive single-lane truth table, back to back
    rst = 1'b0;
    drive1(1'b1, 1'b0, 1'b0); step(); check1("tt00", 1'b1, 1'b0, 1'b0);
    drive1(1'b1, 1'b0, 1'b1); step(); check1("tt01", 1'b1, 1'b0, 1'b1);
    drive1(1'b1, 1'b1, 1'b0); step(); check1("tt10", 1'b1, 1'b0, 1'b1);
    drive1(1'b1, 1'b1, 1'b1); step(); check1("tt11", 1'b1, 1'b1, 1'b0);

    // Hold: idle operands must not disturb the last result
    drive1(1'b1, 1'b1, 1'b0); step(); check1("hold_load", 1'b1, 1'b0, 1'b1);
    drive1(1'b0, 1'b1, 1'b1); step(); check1("hold1", 1'b0, 1'b0, 1'b1);
    step(); check1("hold2", 1'b0, 1'b0, 1'b1);
    step(); check1("hold3", 1'b0, 1'b0, 1'b1);

    // Multi-lane, no carry between lanes
    if4.a = 4'b1100; if4.b = 4'b1010; step(); check4("ml_c_a", 4'b1000, 4'b0110);
    if4.a = 4'b0101; if4.b = 4'b0011; step(); check4("ml_5_3", 4'b0001, 4'b0110);
    if4.a = 4'b1111; if4.b = 4'b0000; step(); check4("ml_f_0", 4'b0000, 4'b1111);
    if4.a = 4'b1111; if4.b = 4'b1111; step(); check4("ml_f_f", 4'b1111, 4'b0000);

    // Reset mid-stream
    drive1(1'b1, 1'b1, 1'b1); step(); check1("mid_pre", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1); step(); check1("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive1(1'b1, 1'b0, 1'b1); step(); check1("mid_post", 1'b1, 1'b0, 1'b1);

    // Full-adder composition over all (A,B,C)
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      logic       exp_s;
      logic       exp_c;
      abc   = i[2:0];
      exp_s = abc[2] ^ abc[1] ^ abc[0];
      exp_c = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
      fa1.a = abc[2];
      fa1.b = abc[1];
      fa_c  = abc[0];
      step();
      step();
      check($sformatf("fa%0d_ov", i), {7'd0, fa2.out_valid}, 8'd1);
      check($sformatf("fa%0d_sum", i), {7'd0, fa_sum}, {7'd0, exp_s});
      check($sformatf("fa%0d_carry", i), {7'd0, fa_carry}, {7'd0, exp_c});
      $display("fa A=%b B=%b C=%b: carry=%b sum=%b", abc[2], abc[1], abc[0],
               fa_carry, fa_sum);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
